// File: rtl/mealey_stim_checker.sv
// Stimulus/response engine for the 9-bit signed Mealy accumulator: drives an
// arithmetic sequence, checks the zero-latency response against a golden model.
module mealey_stim_checker #(
    parameter int unsigned       NUM_SAMPLES = 100,
    parameter logic signed [8:0] START_VAL   = -9'sd8,
    parameter logic signed [8:0] STEP        = 9'sd3
) (
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              start,
    output logic signed [8:0] dut_in,
    input  logic signed [8:0] dut_out,
    output logic              mismatch,
    output logic [15:0]       err_count,
    output logic [15:0]       first_err_idx,
    output logic              done,
    output logic              pass
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_SAMPLES - 1);

    state_t            state, state_nxt;
    logic signed [8:0] x_q, x_nxt;
    logic signed [8:0] acc_m, acc_nxt;
    logic [15:0]       idx, idx_nxt;
    logic [15:0]       err_nxt, first_nxt;
    logic              mm_nxt;
    logic signed [8:0] exp_v;
    logic              miscmp;

    // Model of the DUT's combinational sum; wraps modulo 512 like the DUT.
    assign exp_v  = acc_m + x_q;
    // Case inequality so an X/Z response is flagged in simulation.
    assign miscmp = (dut_out !== exp_v);

    assign dut_in = x_q;
    assign done   = (state == DONE);
    assign pass   = done && (err_count == 16'd0);

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state         <= IDLE;
            x_q           <= '0;
            acc_m         <= '0;
            idx           <= '0;
            mismatch      <= 1'b0;
            err_count     <= '0;
            first_err_idx <= 16'hFFFF;
        end else begin
            state         <= state_nxt;
            x_q           <= x_nxt;
            acc_m         <= acc_nxt;
            idx           <= idx_nxt;
            mismatch      <= mm_nxt;
            err_count     <= err_nxt;
            first_err_idx <= first_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        acc_nxt   = acc_m;
        idx_nxt   = idx;
        mm_nxt    = 1'b0;
        err_nxt   = err_count;
        first_nxt = first_err_idx;
        case (state)
            IDLE: begin
                x_nxt = '0;
                if (start) begin
                    state_nxt = RUN;
                    x_nxt     = START_VAL;
                    idx_nxt   = '0;
                end
            end
            RUN: begin
                acc_nxt = exp_v;
                x_nxt   = x_q + STEP;
                idx_nxt = idx + 16'd1;
                if (miscmp) begin
                    mm_nxt = 1'b1;
                    if (err_count != 16'hFFFF) err_nxt = err_count + 16'd1;
                    if (err_count == 16'd0) first_nxt = idx;
                end
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                    x_nxt     = '0;
                end
            end
            DONE: x_nxt = '0;
            default: begin
                state_nxt = IDLE;
                x_nxt     = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_mealey_stim_checker.sv
// Directed bench: behavioural accumulator DUTs with fault modes beside three
// checker configurations (defaults, wrap case, single sample).
module tb_mealey_stim_checker;

    logic clk = 1'b0;
    logic rstn;
    logic start;
    int   mode;   // 0 ideal, 1 flip LSB at sample 37, 2 stuck at 0
    int   cyc;
    int   checks = 0;
    int   failures = 0;
    int   mm_cnt;
    int   mm_cyc;

    always #5 clk = ~clk;

    logic signed [8:0] in_a, out_a, acc_a, sum_a;
    logic signed [8:0] in_b, out_b, acc_b;
    logic signed [8:0] in_c, out_c, acc_c;
    logic              mm_a, done_a, pass_a, mm_b, done_b, pass_b, mm_c, done_c, pass_c;
    logic [15:0]       err_a, first_a, err_b, first_b, err_c, first_c;

    assign sum_a = acc_a + in_a;
    assign out_a = (mode == 2) ? 9'sd0 : ((mode == 1 && cyc == 37) ? (sum_a ^ 9'sd1) : sum_a);
    assign out_b = acc_b + in_b;
    assign out_c = acc_c + in_c;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_a <= '0; acc_b <= '0; acc_c <= '0; cyc <= -1;
        end else begin
            acc_a <= sum_a; acc_b <= out_b; acc_c <= out_c;
            if (cyc < 0 && start) cyc <= 0;
            else if (cyc >= 0)    cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rstn) mm_cnt = 0;
        else if (mm_a) begin mm_cnt = mm_cnt + 1; mm_cyc = cyc; end
    end

    mealey_stim_checker u_a (
        .system1000(clk), .system1000_rstn(rstn), .start(start),
        .dut_in(in_a), .dut_out(out_a), .mismatch(mm_a), .err_count(err_a),
        .first_err_idx(first_a), .done(done_a), .pass(pass_a));

    mealey_stim_checker #(.NUM_SAMPLES(4), .START_VAL(9'sd255), .STEP(9'sd1)) u_b (
        .system1000(clk), .system1000_rstn(rstn), .start(start),
        .dut_in(in_b), .dut_out(out_b), .mismatch(mm_b), .err_count(err_b),
        .first_err_idx(first_b), .done(done_b), .pass(pass_b));

    mealey_stim_checker #(.NUM_SAMPLES(1)) u_c (
        .system1000(clk), .system1000_rstn(rstn), .start(start),
        .dut_in(in_c), .dut_out(out_c), .mismatch(mm_c), .err_count(err_c),
        .first_err_idx(first_c), .done(done_c), .pass(pass_c));

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int m);
        @(negedge clk);
        rstn  = 1'b0;
        start = 1'b0;
        mode  = m;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic pulse_start(input logic hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = hold;
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n + 20 && cyc < n; i++) @(negedge clk);
        chk("wait_cyc_timeout", cyc, n);
    endtask

    logic signed [8:0] b_in_tbl  [4] = '{9'sd255, -9'sd256, -9'sd255, -9'sd254};
    logic signed [8:0] b_out_tbl [4] = '{9'sd255, -9'sd1, -9'sd256, 9'sd2};

    initial begin
        int exp_stuck;
        logic signed [8:0] m_acc, m_x, m_e;

        rstn = 1'b0; start = 1'b0; mode = 0;
        #23;
        chk("rst_dut_in", in_a, 0);
        chk("rst_mismatch", mm_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_first", first_a, 32'hFFFF);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        @(negedge clk) rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_dut_in", in_a, 0);

        // Ideal run, all three configurations
        pulse_start(1'b0);
        for (int i = 0; i < 110 && cyc <= 101; i++) begin
            @(negedge clk);
            if (cyc < 3) chk($sformatf("a_in%0d", cyc), in_a, -8 + 3 * cyc);
            if (cyc < 4) begin
                chk($sformatf("b_in%0d", cyc), in_b, b_in_tbl[cyc]);
                chk($sformatf("b_exp%0d", cyc), out_b, b_out_tbl[cyc]);
            end
            if (cyc == 0) chk("c_done0", done_c, 0);
            if (cyc == 1) begin
                chk("c_done1", done_c, 1); chk("c_pass", pass_c, 1); chk("c_err", err_c, 0);
            end
            if (cyc == 4) begin
                chk("b_done", done_b, 1); chk("b_pass", pass_b, 1);
                chk("b_err", err_b, 0); chk("b_in_after", in_b, 0);
            end
            if (cyc == 99)  chk("a_done99", done_a, 0);
            if (cyc == 100) begin
                chk("a_done100", done_a, 1); chk("a_pass", pass_a, 1);
                chk("a_err", err_a, 0); chk("a_first", first_a, 32'hFFFF);
                chk("a_in_done", in_a, 0);
            end
        end
        chk("a_mm_none", mm_cnt, 0);

        // Single flipped LSB at sample 37
        do_reset(1);
        pulse_start(1'b0);
        wait_cyc(101);
        chk("f_mm_cnt", mm_cnt, 1);
        chk("f_mm_cyc", mm_cyc, 38);
        chk("f_err", err_a, 1);
        chk("f_first", first_a, 37);
        chk("f_done", done_a, 1);
        chk("f_pass", pass_a, 0);

        // Stuck-at-zero DUT; expected count is the number of nonzero sums
        exp_stuck = 0; m_acc = '0; m_x = -9'sd8;
        for (int n = 0; n < 100; n++) begin
            m_e = m_acc + m_x;
            if (m_e != 9'sd0) exp_stuck++;
            m_acc = m_e;
            m_x = m_x + 9'sd3;
        end
        do_reset(2);
        pulse_start(1'b0);
        wait_cyc(101);
        chk("s_err", err_a, exp_stuck);
        chk("s_mm_cnt", mm_cnt, exp_stuck);
        chk("s_first", first_a, 0);
        chk("s_done", done_a, 1);
        chk("s_pass", pass_a, 0);

        // Asynchronous reset mid-run, then a clean run
        do_reset(2);
        pulse_start(1'b0);
        wait_cyc(50);
        chk("m_pre_first", first_a, 0);
        chk("m_pre_mm", mm_a, 1);
        #2 rstn = 1'b0;
        #1;
        chk("m_rst_in", in_a, 0);
        chk("m_rst_mm", mm_a, 0);
        chk("m_rst_err", err_a, 0);
        chk("m_rst_first", first_a, 32'hFFFF);
        chk("m_rst_done", done_a, 0);
        chk("m_rst_pass", pass_a, 0);
        do_reset(0);
        pulse_start(1'b0);
        wait_cyc(100);
        chk("m_done", done_a, 1);
        chk("m_pass", pass_a, 1);

        // start held high through RUN and DONE
        do_reset(0);
        pulse_start(1'b1);
        wait_cyc(10);
        chk("h_in10", in_a, 22);
        wait_cyc(99);
        chk("h_done99", done_a, 0);
        wait_cyc(100);
        chk("h_done100", done_a, 1);
        wait_cyc(150);
        chk("h_done150", done_a, 1);
        chk("h_pass", pass_a, 1);
        chk("h_err", err_a, 0);
        chk("h_in", in_a, 0);
        chk("h_mm_cnt", mm_cnt, 0);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
